// File: rtl/mem_port_arbiter.sv
// Serialises the two memory-stage lanes onto the single data-memory port, lane 0 first.
// Optional macro ARB_ST2LD_FWD_EN: forward lane 0 store data to a same-word lane 1 load.
module mem_port_arbiter #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memtoregm,
  input  logic          memwritem,
  input  logic [DW-1:0] aluoutm,
  input  logic [DW-1:0] writedatam,
  input  logic          memtoregm2,
  input  logic          memwritem2,
  input  logic [DW-1:0] aluoutm2,
  input  logic [DW-1:0] writedatam2,
  output logic          stallm,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [DW-1:0] readdatam,
  output logic [DW-1:0] readdatam2
);

  typedef enum logic [1:0] {StIdle, StL0, StL1, StDone} state_e;

  state_e state_q, state_d;

  logic act0, act1, any_act, fwd_hit;

  // Captured lane state for the duration of one pipeline stall.
  logic          l0_ld_q;
  logic          l1_act_q;
  logic          l1_we_q;
  logic [DW-1:0] l1_addr_q;
  logic [DW-1:0] l1_wdata_q;
  logic          fwd_q;
`ifdef ARB_ST2LD_FWD_EN
  logic [DW-1:0] l0_wdata_q;
`endif

  // A lane asserting both load and store is a store.
  assign act0    = memtoregm | memwritem;
  assign act1    = memtoregm2 | memwritem2;
  assign any_act = act0 | act1;

`ifdef ARB_ST2LD_FWD_EN
  assign fwd_hit = act0 & act1 & memwritem & memtoregm2 & ~memwritem2 &
                   (aluoutm[DW-1:2] == aluoutm2[DW-1:2]);
`else
  assign fwd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (act0) begin
          state_d = StL0;
        end else if (act1) begin
          state_d = StL1;
        end
      end
      StL0: begin
        if (dmem_ack) begin
          state_d = (l1_act_q && !fwd_q) ? StL1 : StDone;
        end
      end
      StL1: begin
        if (dmem_ack) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stallm = 1'b0;
    unique case (state_q)
      StIdle:     stallm = any_act;
      StL0, StL1: stallm = 1'b1;
      default:    stallm = 1'b0;
    endcase
  end

  // Async reset also drops dmem_req at once, abandoning any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      readdatam  <= '0;
      readdatam2 <= '0;
      l0_ld_q    <= 1'b0;
      l1_act_q   <= 1'b0;
      l1_we_q    <= 1'b0;
      l1_addr_q  <= '0;
      l1_wdata_q <= '0;
      fwd_q      <= 1'b0;
`ifdef ARB_ST2LD_FWD_EN
      l0_wdata_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_act) begin
            dmem_req   <= 1'b1;
            dmem_we    <= act0 ? memwritem : memwritem2;
            dmem_addr  <= act0 ? aluoutm : aluoutm2;
            dmem_wdata <= act0 ? writedatam : writedatam2;
            l0_ld_q    <= act0 & ~memwritem;
            l1_act_q   <= act1;
            l1_we_q    <= memwritem2;
            l1_addr_q  <= aluoutm2;
            l1_wdata_q <= writedatam2;
            fwd_q      <= fwd_hit;
`ifdef ARB_ST2LD_FWD_EN
            l0_wdata_q <= writedatam;
`endif
          end
        end
        StL0: begin
          if (dmem_ack) begin
            if (l0_ld_q) begin
              readdatam <= dmem_rdata;
            end
            if (fwd_q) begin
`ifdef ARB_ST2LD_FWD_EN
              readdatam2 <= l0_wdata_q;
`endif
              dmem_req <= 1'b0;
            end else if (l1_act_q) begin
              dmem_we    <= l1_we_q;
              dmem_addr  <= l1_addr_q;
              dmem_wdata <= l1_wdata_q;
            end else begin
              dmem_req <= 1'b0;
            end
          end
        end
        StL1: begin
          if (dmem_ack) begin
            if (!l1_we_q) begin
              readdatam2 <= dmem_rdata;
            end
            dmem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: randomized and directed lane pairs against a word-level memory model.
module tb_mem_port_arbiter;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          memtoregm, memwritem, memtoregm2, memwritem2;
  logic [DW-1:0] aluoutm, writedatam, aluoutm2, writedatam2;
  logic          stallm, dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata, readdatam, readdatam2;

  int checks = 0;
  int errors = 0;

  // Memory environment: automatic responder or manual drive.
  logic          auto_mem;
  logic          ack_drv, man_ack;
  logic [DW-1:0] rdata_drv, man_rdata;
  logic [DW-1:0] mem [logic [29:0]];
  logic [DW-1:0] ref_mem [logic [29:0]];
  int            waitq [$];
  logic [DW-1:0] iss_addr [$];
  logic          iss_we [$];
  logic [DW-1:0] iss_wdata [$];

  logic [DW-1:0] exp_rd0, exp_rd1;
  int            last_stalls, last_issues;

  assign dmem_ack   = auto_mem ? ack_drv : man_ack;
  assign dmem_rdata = auto_mem ? rdata_drv : man_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .memtoregm  (memtoregm),
    .memwritem  (memwritem),
    .aluoutm    (aluoutm),
    .writedatam (writedatam),
    .memtoregm2 (memtoregm2),
    .memwritem2 (memwritem2),
    .aluoutm2   (aluoutm2),
    .writedatam2(writedatam2),
    .stallm     (stallm),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .readdatam  (readdatam),
    .readdatam2 (readdatam2)
  );

  function automatic logic [DW-1:0] init_val(input logic [29:0] w);
    return {w, 2'b01} ^ 32'hC3A5_0F96;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [DW-1:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_val(a[31:2]);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [DW-1:0] a, input logic [DW-1:0] d);
    mem[a[31:2]]     = d;
    ref_mem[a[31:2]] = d;
  endtask

  task automatic clear_lanes();
    memtoregm = 0; memwritem = 0; aluoutm = 0; writedatam = 0;
    memtoregm2 = 0; memwritem2 = 0; aluoutm2 = 0; writedatam2 = 0;
  endtask

  // Responder: per access, waits the queued number of cycles then acks for one cycle.
  initial begin
    bit            busy = 0;
    int            wcnt = 0;
    int            cur_wait = 0;
    logic [DW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic          cap_we = 0;
    ack_drv   = 0;
    rdata_drv = '0;
    forever begin
      @(negedge clk);
      if (ack_drv) begin
        ack_drv = 0;
        busy    = 0;
      end
      rdata_drv = $urandom;
      if (!auto_mem || !dmem_req) begin
        busy = 0;
      end else begin
        if (!busy) begin
          busy      = 1;
          wcnt      = 0;
          cur_wait  = (waitq.size() > 0) ? waitq.pop_front() : 0;
          cap_addr  = dmem_addr;
          cap_we    = dmem_we;
          cap_wdata = dmem_wdata;
          iss_addr.push_back(dmem_addr);
          iss_we.push_back(dmem_we);
          iss_wdata.push_back(dmem_wdata);
        end else begin
          check("req_stable_addr", dmem_addr, cap_addr);
          check("req_stable_we", dmem_we, cap_we);
          if (cap_we) check("req_stable_wdata", dmem_wdata, cap_wdata);
        end
        if (wcnt == cur_wait) begin
          ack_drv = 1;
          if (dmem_we) mem[dmem_addr[31:2]] = dmem_wdata;
          else rdata_drv = mem.exists(dmem_addr[31:2]) ? mem[dmem_addr[31:2]]
                                                        : init_val(dmem_addr[31:2]);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // One lane pair: model says which accesses go to memory, in what order, and the stall length.
  task automatic run_txn(input logic ld0, input logic st0, input logic [DW-1:0] a0,
                         input logic [DW-1:0] d0, input logic ld1, input logic st1,
                         input logic [DW-1:0] a1, input logic [DW-1:0] d1,
                         input int w0, input int w1, input string tag);
    logic          act0, act1, fwd, done;
    int            n, exp_stall, cnt;
    logic [DW-1:0] ea [$];
    logic          ew [$];
    logic [DW-1:0] ed [$];
    act0 = ld0 | st0;
    act1 = ld1 | st1;
    fwd  = 0;
`ifdef ARB_ST2LD_FWD_EN
    fwd = act0 && act1 && st0 && !st1 && (a0[31:2] == a1[31:2]);
`endif
    n = 0;
    @(posedge clk);
    iss_addr.delete(); iss_we.delete(); iss_wdata.delete(); waitq.delete();
    if (act0) begin
      n += w0 + 1;
      waitq.push_back(w0);
      ea.push_back(a0); ew.push_back(st0); ed.push_back(d0);
      if (st0) ref_mem[a0[31:2]] = d0;
      else exp_rd0 = ref_rd(a0);
    end
    if (act1) begin
      if (!fwd) begin
        n += w1 + 1;
        waitq.push_back(w1);
        ea.push_back(a1); ew.push_back(st1); ed.push_back(d1);
      end
      if (st1) ref_mem[a1[31:2]] = d1;
      else exp_rd1 = ref_rd(a1);
    end
    exp_stall = (act0 || act1) ? n + 1 : 0;

    @(negedge clk);
    memtoregm = ld0; memwritem = st0; aluoutm = a0; writedatam = d0;
    memtoregm2 = ld1; memwritem2 = st1; aluoutm2 = a1; writedatam2 = d1;
    #1;
    cnt  = 0;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (stallm !== 1'b1) done = 1;
      else begin
        cnt++;
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_no_timeout"}, done, 1'b1);
    check({tag, "_stall_cycles"}, cnt, exp_stall);
    check({tag, "_req_low_done"}, dmem_req, 1'b0);
    check({tag, "_readdatam"}, readdatam, exp_rd0);
    check({tag, "_readdatam2"}, readdatam2, exp_rd1);
    check({tag, "_issue_count"}, iss_addr.size(), ea.size());
    if (iss_addr.size() == ea.size()) begin
      for (int i = 0; i < ea.size(); i++) begin
        check({tag, "_issue_addr"}, iss_addr[i], ea[i]);
        check({tag, "_issue_we"}, iss_we[i], ew[i]);
        if (ew[i]) check({tag, "_issue_wdata"}, iss_wdata[i], ed[i]);
      end
    end
    last_stalls = cnt;
    last_issues = iss_addr.size();
    clear_lanes();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    clear_lanes();
    auto_mem  = 1;
    man_ack   = 0;
    man_rdata = '0;
    exp_rd0   = '0;
    exp_rd1   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_stallm", stallm, 1'b0);
      check("idle_req", dmem_req, 1'b0);
      check("idle_rd0", readdatam, '0);
      check("idle_rd1", readdatam2, '0);
    end

    // Lane 0 store, zero-wait.
    run_txn(0, 1, 32'h40, 32'hDEADBEEF, 0, 0, '0, '0, 0, 0, "st0");
    check("st0_stall2", last_stalls, 2);
    check("st0_rd0_kept", readdatam, 32'h0);
    check("st0_rd1_kept", readdatam2, 32'h0);

    // Two loads, two wait cycles each.
    preload(32'h10, 32'h11111111);
    preload(32'h14, 32'h22222222);
    run_txn(1, 0, 32'h10, '0, 1, 0, 32'h14, '0, 2, 2, "ld2");
    check("ld2_stall7", last_stalls, 7);
    check("ld2_rd0", readdatam, 32'h11111111);
    check("ld2_rd1", readdatam2, 32'h22222222);

    // Store then load to the same word.
    run_txn(0, 1, 32'h80, 32'hA5A5A5A5, 1, 0, 32'h80, '0, 0, 0, "st2ld");
    check("st2ld_rd1", readdatam2, 32'hA5A5A5A5);
`ifdef ARB_ST2LD_FWD_EN
    check("st2ld_stall", last_stalls, 2);
    check("st2ld_issues", last_issues, 1);
`else
    check("st2ld_stall", last_stalls, 3);
    check("st2ld_issues", last_issues, 2);
`endif

    // Lane 1 only.
    preload(32'h20, 32'h33333333);
    run_txn(0, 0, '0, '0, 1, 0, 32'h20, '0, 0, 0, "ld1only");
    check("ld1only_stall2", last_stalls, 2);
    check("ld1only_rd0_kept", readdatam, 32'h11111111);
    check("ld1only_rd1", readdatam2, 32'h33333333);

    // Reset while waiting in L0; a late ack must be ignored.
    auto_mem = 0;
    @(posedge clk);
    @(negedge clk);
    memtoregm = 1; aluoutm = 32'h30;
    @(posedge clk);
    #1;
    check("rst_req_before", dmem_req, 1'b1);
    @(posedge clk);
    #2;
    clear_lanes();
    rst = 1;
    #1;
    check("rst_req_async", dmem_req, 1'b0);
    check("rst_stallm", stallm, 1'b0);
    @(negedge clk);
    rst       = 0;
    man_ack   = 1;
    man_rdata = 32'h0BAD0BAD;
    @(posedge clk);
    #1;
    check("rst_late_ack_req", dmem_req, 1'b0);
    check("rst_late_ack_stall", stallm, 1'b0);
    check("rst_late_ack_rd0", readdatam, 32'h0);
    check("rst_late_ack_rd1", readdatam2, 32'h0);
    @(negedge clk);
    man_ack  = 0;
    auto_mem = 1;
    exp_rd0  = '0;
    exp_rd1  = '0;

    // Randomized lane pairs over a small address window to provoke same-word collisions.
    for (int t = 0; t < 40; t++) begin
      int            m0, m1;
      logic [DW-1:0] a0, a1;
      m0 = $urandom_range(0, 3);
      m1 = $urandom_range(0, 3);
      a0 = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      a1 = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      run_txn(m0[0], m0[1], a0, $urandom, m1[0], m1[1], a1, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the two memory-stage lanes of the dual-issue pipeline onto the single-port data memory. It sits between the EX/MEM pipeline register outputs and the data memory. When either lane requests a load or store, it stalls the pipeline and serves the lanes one at a time, lane 0 first (program order). It returns load data per lane.

## Interface
- `DW`, default 32: data and address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `memtoregm` in 1: lane 0 load request.
- `memwritem` in 1: lane 0 store request.
- `aluoutm` in DW: lane 0 byte address.
- `writedatam` in DW: lane 0 store data.
- `memtoregm2`, `memwritem2`, `aluoutm2`, `writedatam2`: the same four signals for lane 1.
- `stallm` out 1: freezes the EX/MEM register and all earlier stages while high. Combinational.
- `dmem_req` out 1: memory request. Registered.
- `dmem_we` out 1: 1 = write, 0 = read. Registered.
- `dmem_addr` out DW: memory address. Registered.
- `dmem_wdata` out DW: memory write data. Registered.
- `dmem_ack` in 1: memory completion. Sampled only while `dmem_req`=1.
- `dmem_rdata` in DW: read data, valid in the cycle where `dmem_ack`=1.
- `readdatam` out DW: lane 0 load result. Registered.
- `readdatam2` out DW: lane 1 load result. Registered.

## Operation
- Lane active = load OR store. If a lane asserts both, it is treated as a store.
- States: IDLE, L0, L1, DONE.
- IDLE
  - No lane active: stay in IDLE, `stallm`=0.
  - Any lane active: `stallm`=1.
  - Capture both lanes' active/we/address/wdata flags.
  - Load `dmem_*` with the first active lane: lane 0 if active, else lane 1.
  - Next state: L0 if lane 0 is active, else L1.
- L0
  - `dmem_req`=1, `stallm`=1. Wait for `dmem_ack`.
  - On ack, if lane 0 was a load: `readdatam` <= `dmem_rdata`.
  - On ack, if lane 1 was captured active: load `dmem_*` with lane 1, go to L1.
  - On ack, if lane 1 was not active: `dmem_req` <= 0, go to DONE.
- L1
  - Same as L0, applied to lane 1 (writes `readdatam2`).
  - On ack: `dmem_req` <= 0, go to DONE.
- DONE
  - `stallm`=0 for exactly one cycle, so the pipeline advances; no new request is issued.
  - Next state: IDLE.
- `stallm` = (IDLE AND any lane active) OR L0 OR L1.
- `readdatam`/`readdatam2` hold their value until the next load on the same lane. Stores never change them.
- Same address on both lanes: strict order, lane 0 then lane 1. A lane 1 read after a lane 0 write returns the new data.
- Reset values:
  - State = IDLE.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` = 0.
  - `readdatam`, `readdatam2` = 0.
  - `stallm` = 0 when no lane is active.
- Reset mid-transaction: `dmem_req` drops to 0 immediately, without waiting for a clock edge. The in-flight access is abandoned, and a later `dmem_ack` is ignored.

## Timing
- Zero-wait memory (ack in the first `dmem_req` cycle):
  - one lane: 2 stall cycles (IDLE, L0), then DONE;
  - two lanes: 3 stall cycles.
- Each extra wait cycle of memory adds one stall cycle.
- `dmem_req`/`dmem_we`/`dmem_addr`/`dmem_wdata` stay stable from assertion until the ack cycle.
- When moving L0→L1, `dmem_req` stays high and address/data change on the ack edge (back-to-back).
- Load data is visible on `readdatam*` in the cycle after the ack, which is at latest the DONE cycle. The pipeline captures it on the DONE clock edge.

## Configuration
- `ARB_ST2LD_FWD_EN` defined:
  - Condition: both lanes active, lane 0 is a store, lane 1 is a load, and `aluoutm[DW-1:2]` == `aluoutm2[DW-1:2]`.
  - Action: on lane 0's ack, `readdatam2` <= captured lane 0 wdata, and the FSM goes straight to DONE. Lane 1 issues no memory access, so the pair costs 2 stall cycles.
- `ARB_ST2LD_FWD_EN` undefined: no comparison; lane 1 is always issued to memory.

## Test plan
- Reset, then no requests.
  - Required: `stallm`=0, `dmem_req`=0, both readdata = 0 over 10 cycles.
- Lane 0 store to 0x40, data 0xDEADBEEF, zero-wait ack.
  - Required: `dmem_req`=1 with `dmem_we`=1, addr 0x40, wdata 0xDEADBEEF for one cycle.
  - Required: `stallm` high for exactly 2 cycles; readdata unchanged.
- Lane 0 load 0x10 plus lane 1 load 0x14; memory returns 0x11111111 and 0x22222222 with 2 wait cycles each.
  - Required: issue order 0x10 then 0x14.
  - Required: `readdatam`=0x11111111, `readdatam2`=0x22222222; 7 stall cycles.
- Lane 0 store 0x80 ← 0xA5A5A5A5 plus lane 1 load 0x80.
  - Fwd off: two accesses; `readdatam2`=0xA5A5A5A5 read back from memory; 3 stall cycles.
  - Fwd on: one access; `readdatam2`=0xA5A5A5A5; 2 stall cycles.
- Lane 1-only load from 0x20.
  - Required: FSM goes IDLE→L1 directly; `readdatam` keeps its prior value.
- `rst` pulsed while in L0 waiting for ack.
  - Required: `dmem_req`=0 immediately, state IDLE.
  - Required: an ack in the next cycle changes nothing.
